// File: rtl/chien_root_finder.sv
// Chien search stage of the RS(15,11) decoder over GF(16), primitive polynomial x^4+x+1.
// Scans k=0..14, streams per-position root flags and reports a two-error summary.

module full_GF_mult (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [3:0] o_p
);
    logic [3:0] w_acc;
    logic [3:0] w_sh;

    // Shift-and-add: w_sh walks i_a * x^i reduced modulo x^4+x+1.
    always_comb begin
        w_acc = 4'd0;
        w_sh  = i_a;
        for (int i = 0; i < 4; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc ^ w_sh;
            end
            w_sh = {w_sh[2:0], 1'b0} ^ (w_sh[3] ? 4'b0011 : 4'b0000);
        end
        o_p = w_acc;
    end
endmodule

module chien_root_finder #(
    parameter logic [3:0] ALPHA_1 = 4'd2,
    parameter logic [3:0] ALPHA_2 = 4'd4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [3:0] LAMBDA0,
    input  logic [3:0] LAMBDA1,
    input  logic [3:0] LAMBDA2,
    input  logic [1:0] DEG,
    output logic       BUSY,
    output logic       EVAL_VALID,
    output logic [3:0] EVAL_POS,
    output logic       ROOT,
    output logic       DONE,
    output logic [1:0] ERR_CNT,
    output logic [3:0] POS0,
    output logic [3:0] POS1,
    output logic       FAIL
);
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEval = 2'd1,
        StFin  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_lam0;
    logic [3:0] r_r1;
    logic [3:0] r_r2;
    logic [3:0] r_k;
    logic [1:0] r_deg;
    logic [1:0] r_err_cnt;
    logic [3:0] r_pos0;
    logic [3:0] r_pos1;
    logic [3:0] w_r1_mul;
    logic [3:0] w_r2_mul;
    logic [3:0] w_sum;
    logic [3:0] w_pos;
    logic       w_eval;
    logic       w_root;
    logic       w_load;

    full_GF_mult u_mul1 (
        .i_a (r_r1),
        .i_b (ALPHA_1),
        .o_p (w_r1_mul)
    );

    full_GF_mult u_mul2 (
        .i_a (r_r2),
        .i_b (ALPHA_2),
        .o_p (w_r2_mul)
    );

    // r1 = L1*a^k and r2 = L2*a^2k, so w_sum is L(a^k).
    assign w_sum  = r_lam0 ^ r_r1 ^ r_r2;
    assign w_eval = (r_state == StEval);
    assign w_root = w_eval && (w_sum == 4'd0);
    assign w_load = (r_state == StIdle) && START;
    assign w_pos  = (r_k == 4'd0) ? 4'd0 : 4'd15 - r_k;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (START) w_state_next = StEval;
            StEval:  if (r_k == 4'd14) w_state_next = StFin;
            StFin:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_lam0    <= 4'd0;
            r_r1      <= 4'd0;
            r_r2      <= 4'd0;
            r_k       <= 4'd0;
            r_deg     <= 2'd0;
            r_err_cnt <= 2'd0;
            r_pos0    <= 4'd0;
            r_pos1    <= 4'd0;
        end else if (w_load) begin
            r_lam0    <= LAMBDA0;
            r_r1      <= LAMBDA1;
            r_r2      <= LAMBDA2;
            r_deg     <= DEG;
            r_k       <= 4'd0;
            r_err_cnt <= 2'd0;
            r_pos0    <= 4'd0;
            r_pos1    <= 4'd0;
        end else if (w_eval) begin
            r_r1 <= w_r1_mul;
            r_r2 <= w_r2_mul;
            r_k  <= r_k + 4'd1;
            if (w_root) begin
                if (r_err_cnt == 2'd0) r_pos0 <= w_pos;
                if (r_err_cnt == 2'd1) r_pos1 <= w_pos;
                // Count saturates at 3; positions beyond the second are dropped.
                if (r_err_cnt != 2'd3) r_err_cnt <= r_err_cnt + 2'd1;
            end
        end
    end

    assign BUSY       = (r_state != StIdle);
    assign EVAL_VALID = w_eval;
    assign EVAL_POS   = w_eval ? w_pos : 4'd0;
    assign ROOT       = w_root;
    assign DONE       = (r_state == StFin);
    assign ERR_CNT    = r_err_cnt;
    assign POS0       = r_pos0;
    assign POS1       = r_pos1;
    assign FAIL       = (r_err_cnt != r_deg);
endmodule

// File: tb/tb_chien_root_finder.sv
// Directed bench for chien_root_finder: known locators with hand-derived root positions.

module tb_chien_root_finder;
    logic       CLK;
    logic       RESET;
    logic       START;
    logic [3:0] LAMBDA0;
    logic [3:0] LAMBDA1;
    logic [3:0] LAMBDA2;
    logic [1:0] DEG;
    logic       BUSY;
    logic       EVAL_VALID;
    logic [3:0] EVAL_POS;
    logic       ROOT;
    logic       DONE;
    logic [1:0] ERR_CNT;
    logic [3:0] POS0;
    logic [3:0] POS1;
    logic       FAIL;

    int n_checks = 0;
    int n_errors = 0;

    chien_root_finder dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .LAMBDA0    (LAMBDA0),
        .LAMBDA1    (LAMBDA1),
        .LAMBDA2    (LAMBDA2),
        .DEG        (DEG),
        .BUSY       (BUSY),
        .EVAL_VALID (EVAL_VALID),
        .EVAL_POS   (EVAL_POS),
        .ROOT       (ROOT),
        .DONE       (DONE),
        .ERR_CNT    (ERR_CNT),
        .POS0       (POS0),
        .POS1       (POS1),
        .FAIL       (FAIL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_scan(input string tag, input logic [3:0] l0, input logic [3:0] l1,
                            input logic [3:0] l2, input logic [1:0] deg,
                            input logic [14:0] exp_mask, input logic [1:0] exp_cnt,
                            input logic [3:0] exp_p0, input logic [3:0] exp_p1,
                            input logic exp_fail, input int repulse_k);
        logic [14:0] root_mask;
        logic [14:0] valid_mask;
        logic [14:0] pos_bad;
        logic [14:0] done_seen;
        logic [9:0]  cleared;
        logic [3:0]  exp_pos;
        @(negedge CLK);
        LAMBDA0 = l0;
        LAMBDA1 = l1;
        LAMBDA2 = l2;
        DEG     = deg;
        START   = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        cleared = '1;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            exp_pos       = 4'((15 - i) % 15);
            root_mask[i]  = ROOT;
            valid_mask[i] = EVAL_VALID;
            pos_bad[i]    = (EVAL_POS !== exp_pos);
            done_seen[i]  = DONE;
            if (i == 0) cleared = {ERR_CNT, POS0, POS1};
            if (i == repulse_k) begin
                START   = 1'b1;
                LAMBDA0 = 4'd0;
                LAMBDA1 = 4'd0;
                LAMBDA2 = 4'd0;
                DEG     = 2'd3;
            end else begin
                START = 1'b0;
            end
        end
        check({tag, ".roots"}, 32'(root_mask), 32'(exp_mask));
        check({tag, ".valid"}, 32'(valid_mask), 32'h7fff);
        check({tag, ".pos_seq"}, 32'(pos_bad), 32'd0);
        check({tag, ".no_early_done"}, 32'(done_seen), 32'd0);
        check({tag, ".cleared"}, 32'(cleared), 32'd0);
        @(negedge CLK);
        START = 1'b0;
        check({tag, ".done"}, 32'({DONE, BUSY, EVAL_VALID, ROOT}), 32'b1100);
        check({tag, ".err_cnt"}, 32'(ERR_CNT), 32'(exp_cnt));
        check({tag, ".pos0"}, 32'(POS0), 32'(exp_p0));
        check({tag, ".pos1"}, 32'(POS1), 32'(exp_p1));
        check({tag, ".fail"}, 32'(FAIL), 32'(exp_fail));
    endtask

    task automatic idle_check(input string tag, input logic [1:0] exp_cnt,
                              input logic [3:0] exp_p0, input logic [3:0] exp_p1,
                              input logic exp_fail);
        @(negedge CLK);
        check({tag, ".idle"}, 32'({BUSY, DONE, EVAL_VALID, EVAL_POS}), 32'd0);
        check({tag, ".held"}, 32'({ERR_CNT, POS0, POS1, FAIL}),
              32'({exp_cnt, exp_p0, exp_p1, exp_fail}));
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        RESET   = 1'b1;
        START   = 1'b0;
        LAMBDA0 = 4'd0;
        LAMBDA1 = 4'd0;
        LAMBDA2 = 4'd0;
        DEG     = 2'd0;
        #1;
        check("reset_outs", 32'({BUSY, EVAL_VALID, ROOT, DONE, EVAL_POS, ERR_CNT, POS0, POS1,
                                 FAIL}), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        idle_check("post_reset", 2'd0, 4'd0, 4'd0, 1'b0);

        // L=(1,8,0): root at k=12 only (pos 3)
        run_scan("single", 4'd1, 4'd8, 4'd0, 2'd1, 15'h1000, 2'd1, 4'd3, 4'd0, 1'b0, -1);
        idle_check("single", 2'd1, 4'd3, 4'd0, 1'b0);

        // L=(1,7,6): roots at k=0 and k=10; START re-pulsed at k=5 must be ignored
        run_scan("two_busy", 4'd1, 4'd7, 4'd6, 2'd2, 15'h0401, 2'd2, 4'd0, 4'd5, 1'b0, 5);

        // Back-to-back: L=(1,0,2), single root at k=7 (pos 8) against DEG=2
        run_scan("deg_mismatch", 4'd1, 4'd0, 4'd2, 2'd2, 15'h0080, 2'd1, 4'd8, 4'd0, 1'b1, -1);
        idle_check("deg_mismatch", 2'd1, 4'd8, 4'd0, 1'b1);

        run_scan("all_zero", 4'd0, 4'd0, 4'd0, 2'd0, 15'h7fff, 2'd3, 4'd0, 4'd14, 1'b1, -1);

        // Back-to-back after a saturated scan: constant nonzero locator, no roots
        run_scan("const", 4'd5, 4'd0, 4'd0, 2'd0, 15'h0000, 2'd0, 4'd0, 4'd0, 1'b0, -1);
        idle_check("const", 2'd0, 4'd0, 4'd0, 1'b0);

        // Abort a (1,7,6) scan at k=6, where ERR_CNT=1 and FAIL=1
        @(negedge CLK);
        LAMBDA0 = 4'd1;
        LAMBDA1 = 4'd7;
        LAMBDA2 = 4'd6;
        DEG     = 2'd2;
        START   = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (7) @(negedge CLK);
        check("abort.pre", 32'({BUSY, EVAL_POS, ERR_CNT, FAIL}), 32'({1'b1, 4'd9, 2'd1, 1'b1}));
        RESET = 1'b1;
        #1;
        check("abort.outs", 32'({BUSY, EVAL_VALID, ROOT, DONE, EVAL_POS, ERR_CNT, POS0, POS1,
                                 FAIL}), 32'd0);
        @(negedge CLK);
        RESET    = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE) done_cnt++;
            if (BUSY) busy_cnt++;
        end
        check("abort.no_done", 32'(done_cnt), 32'd0);
        check("abort.no_busy", 32'(busy_cnt), 32'd0);

        run_scan("after_abort", 4'd1, 4'd8, 4'd0, 2'd1, 15'h1000, 2'd1, 4'd3, 4'd0, 1'b0, -1);
        idle_check("after_abort", 2'd1, 4'd3, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
